// File: rtl/traffic_ctrl_multi_if.sv
// Controller-side signal bundle for traffic_ctrl_multi: timebase/demand/maintenance in,
// lamp state, owning direction and phase out.
interface traffic_ctrl_multi_if #(
  parameter int unsigned NUM_DIR = 4
);
  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  logic                   tick;
  logic [NUM_DIR-1:0]     req;
  logic                   flash;
  logic [3*NUM_DIR-1:0]   light;
  logic [DIR_W-1:0]       active_dir;
  logic [1:0]             phase;

  modport master (
    output tick, req, flash,
    input  light, active_dir, phase
  );

  modport slave (
    input  tick, req, flash,
    output light, active_dir, phase
  );
endinterface

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic light controller: round-robin right-of-way with demand skipping,
// green extension for a lone requester, and a maintenance flash mode.
module traffic_ctrl_multi #(
  parameter int unsigned NUM_DIR  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_ctrl_multi_if.slave  bus
);
  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  localparam logic [CNT_W-1:0] LD_G = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] LD_Y = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_A = CNT_W'(ALLRED_T - 1);

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;
  localparam logic [2:0] L_OFF    = 3'b000;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_FLASH  = 2'b11
  } phase_e;

  phase_e               r_phase, w_phase_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [DIR_W-1:0]     r_dir, w_dir_nx, w_rr_dir;
  logic                 r_blink, w_blink_nx;
  logic [3*NUM_DIR-1:0] r_light, w_light_nx;
  logic [NUM_DIR-1:0]   w_others;

  // Round-robin search starting after r_dir; r_dir itself is visited last (k = NUM_DIR).
  always_comb begin : rr_search
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    w_rr_dir = DIR_W'((32'(r_dir) + 1) % NUM_DIR);
    for (int unsigned k = 1; k <= NUM_DIR; k++) begin
      idx = (32'(r_dir) + k) % NUM_DIR;
      if (!found && bus.req[DIR_W'(idx)]) begin
        found    = 1'b1;
        w_rr_dir = DIR_W'(idx);
      end
    end
  end

  always_comb begin
    w_others        = bus.req;
    w_others[r_dir] = 1'b0;
  end

  always_comb begin
    w_phase_nx = r_phase;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_blink_nx = r_blink;
    if (bus.tick) begin
      if (bus.flash) begin
        w_phase_nx = PH_FLASH;
        w_blink_nx = (r_phase == PH_FLASH) ? ~r_blink : 1'b1;
      end else if (r_phase == PH_FLASH) begin
        w_phase_nx = PH_ALLRED;
        w_cnt_nx   = LD_A;
        w_blink_nx = 1'b0;
      end else if (r_cnt != '0) begin
        w_cnt_nx = r_cnt - CNT_W'(1);
      end else begin
        unique case (r_phase)
          PH_ALLRED: begin
            w_phase_nx = PH_GREEN;
            w_cnt_nx   = LD_G;
            w_dir_nx   = w_rr_dir;
          end
          PH_GREEN: begin
            if (bus.req[r_dir] && (w_others == '0)) begin
              w_cnt_nx = LD_G;
            end else begin
              w_phase_nx = PH_YELLOW;
              w_cnt_nx   = LD_Y;
            end
          end
          PH_YELLOW: begin
            w_phase_nx = PH_ALLRED;
            w_cnt_nx   = LD_A;
          end
          default: ;
        endcase
      end
    end
  end

  // Lamp pattern is decoded from the next state so the light register tracks phase exactly.
  always_comb begin
    w_light_nx = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      logic [2:0] lamp;
      lamp = L_RED;
      if (w_phase_nx == PH_FLASH) begin
        lamp = w_blink_nx ? L_YELLOW : L_OFF;
      end else if (DIR_W'(d) == w_dir_nx) begin
        unique case (w_phase_nx)
          PH_GREEN:  lamp = L_GREEN;
          PH_YELLOW: lamp = L_YELLOW;
          default:   lamp = L_RED;
        endcase
      end
      w_light_nx[3*d +: 3] = lamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_ALLRED;
      r_cnt   <= LD_A;
      r_dir   <= DIR_W'(NUM_DIR - 1);
      r_blink <= 1'b0;
      r_light <= {NUM_DIR{L_RED}};
    end else begin
      r_phase <= w_phase_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_blink <= w_blink_nx;
      r_light <= w_light_nx;
    end
  end

  assign bus.light      = r_light;
  assign bus.phase      = r_phase;
  assign bus.active_dir = r_dir;
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Scoreboard bench for traffic_ctrl_multi (default parameters): directed segments push
// hand-computed lamp/phase/direction expectations; a monitor pops and compares them.
module tb_traffic_ctrl_multi;
  logic clk = 1'b0;
  logic rst_n;

  traffic_ctrl_multi_if #(.NUM_DIR(4)) bus ();

  traffic_ctrl_multi #(
    .NUM_DIR (4),
    .CNT_W   (8),
    .GREEN_T (20),
    .YELLOW_T(4),
    .ALLRED_T(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] light;
    logic [1:0]  phase;
    logic [1:0]  dir;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   tph     = 0;
  event ev_async;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expectation for the state observed right now (used around asynchronous reset).
  task automatic expect_now(input string tag, input logic [11:0] lt,
                            input logic [1:0] ph, input logic [1:0] d);
    exp_t e;
    e.cyc = cyc_cnt; e.tag = tag; e.light = lt; e.phase = ph; e.dir = d;
    q.push_back(e);
    -> ev_async;
  endtask

  // mode 0: tick every cycle, 1: tick held low, 2: tick every 3rd cycle (continuous phase).
  task automatic seg(input string tag, input int n, input int mode, input logic [3:0] rq,
                     input logic fl, input logic [11:0] lt, input logic [1:0] ph,
                     input logic [1:0] d);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       bus.tick = 1'b1;
        1:       bus.tick = 1'b0;
        default: begin bus.tick = ((tph % 3) == 2); tph++; end
      endcase
      bus.req   = rq;
      bus.flash = fl;
      e.cyc = cyc_cnt + 1; e.tag = tag; e.light = lt; e.phase = ph; e.dir = d;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or ev_async);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        checks++;
        if (bus.light !== e.light || bus.phase !== e.phase || bus.active_dir !== e.dir) begin
          errors++;
          $display("FAIL %s cyc=%0d got light=%h phase=%b dir=%0d, want light=%h phase=%b dir=%0d",
                   e.tag, e.cyc, bus.light, bus.phase, bus.active_dir, e.light, e.phase, e.dir);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n     = 1'b0;
    bus.tick  = 1'b0;
    bus.req   = '0;
    bus.flash = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_state", 12'h924, 2'b00, 2'd3);
    rst_n = 1'b1;

    // Free-running rotation with no demand
    seg("rot_allred0",  1, 0, 4'b0000, 1'b0, 12'h924, 2'b00, 2'd3);
    seg("rot_green0",  20, 0, 4'b0000, 1'b0, 12'h922, 2'b01, 2'd0);
    seg("rot_yellow0",  4, 0, 4'b0000, 1'b0, 12'h921, 2'b10, 2'd0);
    seg("rot_allred1",  2, 0, 4'b0000, 1'b0, 12'h924, 2'b00, 2'd0);
    seg("rot_green1",  20, 0, 4'b0000, 1'b0, 12'h914, 2'b01, 2'd1);
    seg("rot_yellow1",  2, 0, 4'b0000, 1'b0, 12'h90C, 2'b10, 2'd1);

    // Asynchronous reset mid-yellow, checked before the next clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", 12'h924, 2'b00, 2'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_now("post_reset", 12'h924, 2'b00, 2'd3);

    // Demand on 0 and 2: direction 1 is skipped
    seg("rr_allred",    1, 0, 4'b0101, 1'b0, 12'h924, 2'b00, 2'd3);
    seg("rr_green0",   20, 0, 4'b0101, 1'b0, 12'h922, 2'b01, 2'd0);
    seg("rr_yellow0",   4, 0, 4'b0101, 1'b0, 12'h921, 2'b10, 2'd0);
    seg("rr_allred0",   2, 0, 4'b0101, 1'b0, 12'h924, 2'b00, 2'd0);
    seg("rr_green2",    1, 0, 4'b0101, 1'b0, 12'h8A4, 2'b01, 2'd2);

    // Lone demand on 3: green held through repeated extensions
    seg("rr_green2b",  19, 0, 4'b1000, 1'b0, 12'h8A4, 2'b01, 2'd2);
    seg("rr_yellow2",   4, 0, 4'b1000, 1'b0, 12'h864, 2'b10, 2'd2);
    seg("rr_allred2",   2, 0, 4'b1000, 1'b0, 12'h924, 2'b00, 2'd2);
    seg("ext_green3",  60, 0, 4'b1000, 1'b0, 12'h524, 2'b01, 2'd3);

    // Tick every third cycle: phases stretch to 3x
    tph = 0;
    seg("div3_green3",  2, 2, 4'b0000, 1'b0, 12'h524, 2'b01, 2'd3);
    seg("div3_yellow3",12, 2, 4'b0000, 1'b0, 12'h324, 2'b10, 2'd3);
    seg("div3_allred3", 6, 2, 4'b0000, 1'b0, 12'h924, 2'b00, 2'd3);
    seg("div3_green0", 60, 2, 4'b0000, 1'b0, 12'h922, 2'b01, 2'd0);

    // Flash from green, blink, frozen while tick low, then exit to all-red
    seg("flash_on",     1, 0, 4'b0000, 1'b1, 12'h249, 2'b11, 2'd0);
    seg("flash_off",    1, 0, 4'b0000, 1'b1, 12'h000, 2'b11, 2'd0);
    seg("flash_on2",    1, 0, 4'b0000, 1'b1, 12'h249, 2'b11, 2'd0);
    seg("flash_hold",   2, 1, 4'b0000, 1'b1, 12'h249, 2'b11, 2'd0);
    seg("flash_hold2",  1, 1, 4'b1111, 1'b0, 12'h249, 2'b11, 2'd0);
    seg("flash_exit",   2, 0, 4'b0000, 1'b0, 12'h924, 2'b00, 2'd0);
    seg("flash_green1", 3, 0, 4'b0000, 1'b0, 12'h914, 2'b01, 2'd1);

    bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_multi.md
TRAFFIC_CTRL_MULTI -- requirements
Module: traffic_ctrl_multi

Interface
REQ-001 Parameter NUM_DIR, default 4, SHALL set the number of controlled approaches (directions); legal range 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the phase tick counter.
REQ-003 Parameter GREEN_T, default 20, SHALL set the GREEN phase length in ticks; legal range 1..2^CNT_W.
REQ-004 Parameter YELLOW_T, default 4, SHALL set the YELLOW phase length in ticks; legal range 1..2^CNT_W.
REQ-005 Parameter ALLRED_T, default 2, SHALL set the all-red clearance length in ticks; legal range 1..2^CNT_W.
REQ-006 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-007 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-008 tick  input  1  SHALL be the timebase enable; the block advances timing only on cycles with tick=1.
REQ-009 req  input  NUM_DIR  SHALL carry per-direction vehicle demand; bit i is demand for direction i.
REQ-010 flash  input  1  SHALL be the maintenance request; while high, all directions flash yellow.
REQ-011 light  output  3*NUM_DIR  SHALL carry the lamp state of direction i on bits [3i+2:3i], encoded RED=100, GREEN=010, YELLOW=001, OFF=000.
REQ-012 active_dir  output  max(1,clog2(NUM_DIR))  SHALL give the index of the direction that currently owns, or last owned, right-of-way.
REQ-013 phase  output  2  SHALL give the controller state: 00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH.

Function
REQ-014 All outputs SHALL be registered (Moore); inputs SHALL affect outputs no earlier than the clock edge after they are sampled.
REQ-015 The phase counter SHALL be loaded with (duration-1) on entry to a phase; on each tick it SHALL decrement if nonzero, and when it is zero the phase SHALL end.
REQ-016 A phase of duration D SHALL last exactly D ticks; with tick held at 1, that is D clock cycles.
REQ-017 On leaving ALLRED, the next direction SHALL be the first i with req[i]=1, searched round-robin from active_dir+1 and wrapping modulo NUM_DIR, with active_dir itself checked last.
REQ-018 If no req bit is set on leaving ALLRED, the next direction SHALL be (active_dir+1) mod NUM_DIR, giving a fixed rotation.
REQ-019 ALLRED SHALL be followed by GREEN for the selected direction.
REQ-020 At the end of GREEN, if req[active_dir]=1 and no other req bit is set, GREEN SHALL be extended by reloading GREEN_T-1; otherwise the controller SHALL enter YELLOW.
REQ-021 YELLOW SHALL be followed by ALLRED.
REQ-022 In ALLRED, GREEN and YELLOW, every direction other than active_dir SHALL show RED; active_dir SHALL show RED, GREEN or YELLOW respectively.
REQ-023 A tick with flash=1 SHALL force FLASH from any state, overriding any phase transition on that tick.
REQ-024 In FLASH, a blink bit SHALL toggle on every tick; all directions SHALL show YELLOW when the bit is 1 and OFF when it is 0.
REQ-025 Entering FLASH SHALL set the blink bit to 1.
REQ-026 A tick with flash=0 while in FLASH SHALL enter ALLRED with ALLRED_T-1 loaded and active_dir unchanged.
REQ-027 Ticks with tick=0 SHALL leave all state and outputs unchanged, regardless of req or flash.
REQ-028 No two directions SHALL ever show GREEN or YELLOW in the same cycle outside FLASH.

Reset
REQ-029 While rst_n=0, the block SHALL immediately, without waiting for clk, set phase=00, counter=ALLRED_T-1, active_dir=NUM_DIR-1, blink=0 and every light field to RED (default: light=12'h924).
REQ-030 Reset asserted mid-phase, including in FLASH, SHALL abandon the phase; after release the normal sequence SHALL restart from ALLRED.

Verification
REQ-031 Reset with defaults, tick=1, req=0, flash=0:
- light=12'h924 for 2 cycles;
- then direction 0 GREEN (12'h922) for 20 cycles, YELLOW (12'h921) for 4 cycles, ALLRED for 2 cycles;
- then direction 1 GREEN.
REQ-032 req=4'b1000 held, tick=1 after reset: direction 3 GREEN; the extension repeats every 20 ticks and YELLOW never occurs.
REQ-033 req=4'b0101 while direction 0 is GREEN: after GREEN_T expiry, 4 ticks YELLOW and 2 ticks ALLRED, then direction 2 GREEN, skipping direction 1.
REQ-034 tick pulsed every 3rd cycle: each phase lasts exactly 3x its tick count in cycles, and outputs change only on cycles following a tick.
REQ-035 flash=1 during GREEN: on the next tick light=12'h249, then alternates with 12'h000 on each tick; on deasserting flash, the next tick gives ALLRED (12'h924) for 2 ticks with active_dir unchanged.
REQ-036 rst_n pulsed low mid-YELLOW, asynchronously to clk: light=12'h924 and phase=00 immediately, and REQ-031's sequence repeats.
